// File: rtl/spi_log_pkg.sv
// Shared definitions for the SPI read logger: opcodes, FSM encodings and the nibble-to-ASCII helper.
package spi_log_pkg;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {
      DecIdle,
      DecCmd,
      DecAddr,
      DecDummy,
      DecData,
      DecIgnore
   } dec_state_e;

   typedef enum logic {
      FmtIdle,
      FmtEmit
   } fmt_state_e;

   // Uppercase hex: 'A' is 8'h37 + 10.
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/spi_log_fifo.sv
// Register FIFO holding completed read records; show-ahead read port, same-cycle push and pop.
module spi_log_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0] count_q;
   logic             do_push, do_pop;

   // Full is judged on pre-pop occupancy, so a push into a full queue is dropped even if it pops.
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count_q == OCC_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + OCC_W'(1);
            2'b01:   count_q <= count_q - OCC_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge mclk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/spi_read_logger.sv
// SPI-flash READ/FAST_READ monitor: tracks the live read address and logs "CC AAAAAA NNNN\r\n" per read.
// Optional address-window filter enabled by defining SPI_LOG_FILTER_EN.
module spi_read_logger
   import spi_log_pkg::*;
#(
   parameter int unsigned ADDR_BYTES = 3,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CS_SYNC    = 3
) (
   input  logic                    mclk,
   input  logic                    reset_n,
   input  logic                    spi_cs,
   input  logic                    rx_strobe,
   input  logic [7:0]              rx_data,
`ifdef SPI_LOG_FILTER_EN
   input  logic [8*ADDR_BYTES-1:0] filt_lo,
   input  logic [8*ADDR_BYTES-1:0] filt_hi,
`endif
   output logic [8*ADDR_BYTES-1:0] read_addr,
   output logic                    read_active,
   output logic [7:0]              log_data,
   output logic                    log_valid,
   input  logic                    log_ready,
   output logic                    overflow
);

   localparam int unsigned AW       = 8 * ADDR_BYTES;
   localparam int unsigned REC_W    = 8 + AW + CNT_W;
   localparam int unsigned POS_ADDR = 3;
   localparam int unsigned POS_SP2  = POS_ADDR + 2 * ADDR_BYTES;
   localparam int unsigned POS_CR   = POS_SP2 + 1 + CNT_W / 4;
   localparam int unsigned NCH      = POS_CR + 2;
   localparam int unsigned IDX_W    = $clog2(NCH);

   // ---------------- reset and CS synchronisers ----------------
   logic [1:0]         rst_sync_q;
   logic               rst_n;
   logic [CS_SYNC-1:0] cs_sync_q;
   logic               cs_fall, cs_rise;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // Reset to the idle (high) level so leaving reset never fakes a CS edge.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) cs_sync_q <= '1;
      else        cs_sync_q <= {cs_sync_q[CS_SYNC-2:0], spi_cs};
   end
   assign cs_fall = cs_sync_q[CS_SYNC-1] && !cs_sync_q[CS_SYNC-2];
   assign cs_rise = !cs_sync_q[CS_SYNC-1] && cs_sync_q[CS_SYNC-2];

   // ---------------- decoder ----------------
   dec_state_e       dec_q, dec_s;
   logic [7:0]       cmd_q, cmd_s;
   logic             fast_q, fast_s;
   logic [2:0]       idx_q, idx_s;
   logic [AW-1:0]    addr_q, addr_s, start_q, start_s, read_addr_q, rd_s;
   logic [CNT_W-1:0] cnt_q, cnt_s;
   logic             read_active_q, overflow_q;
   logic             in_range, push;
   logic [REC_W-1:0] fifo_rdata;
   logic             fifo_full, fifo_empty, fifo_pop;

   // Effect of this cycle's strobe; CS edges are layered on top of it in the register block.
   always_comb begin
      dec_s   = dec_q;
      cmd_s   = cmd_q;
      fast_s  = fast_q;
      idx_s   = idx_q;
      addr_s  = addr_q;
      start_s = start_q;
      cnt_s   = cnt_q;
      rd_s    = read_addr_q;
      if (rx_strobe) begin
         unique case (dec_q)
            DecCmd: begin
               cmd_s = rx_data;
               if (rx_data == OP_READ || rx_data == OP_FAST_READ) begin
                  dec_s  = DecAddr;
                  fast_s = (rx_data == OP_FAST_READ);
               end else begin
                  dec_s = DecIgnore;
               end
            end
            DecAddr: begin
               addr_s = {addr_q[AW-9:0], rx_data};
               if (idx_q == 3'(ADDR_BYTES - 1)) begin
                  dec_s   = fast_q ? DecDummy : DecData;
                  start_s = addr_s;
                  rd_s    = addr_s;
               end else begin
                  idx_s = idx_q + 3'd1;
               end
            end
            DecDummy: dec_s = DecData;
            DecData: begin
               rd_s = read_addr_q + AW'(1);
               if (cnt_q != '1) cnt_s = cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_LOG_FILTER_EN
   assign in_range = (start_s >= filt_lo) && (start_s <= filt_hi);
`else
   assign in_range = 1'b1;
`endif

   assign push = cs_rise && (dec_s == DecData) && in_range;

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q         <= DecIdle;
         cmd_q         <= '0;
         fast_q        <= 1'b0;
         idx_q         <= '0;
         addr_q        <= '0;
         start_q       <= '0;
         cnt_q         <= '0;
         read_addr_q   <= '0;
         read_active_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         cmd_q       <= cmd_s;
         fast_q      <= fast_s;
         start_q     <= start_s;
         read_addr_q <= rd_s;
         if (cs_fall) begin
            dec_q         <= DecCmd;
            idx_q         <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            read_active_q <= 1'b0;
         end else begin
            dec_q         <= cs_rise ? DecIdle : dec_s;
            idx_q         <= idx_s;
            addr_q        <= addr_s;
            cnt_q         <= cnt_s;
            read_active_q <= !cs_rise && (dec_s == DecData);
         end
         if (push && fifo_full) overflow_q <= 1'b1;
      end
   end

   spi_log_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .mclk      (mclk),
      .reset_n   (rst_n),
      .push      (push),
      .push_data ({cmd_s, start_s, cnt_s}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ---------------- formatter ----------------
   fmt_state_e       fmt_q;
   logic [IDX_W-1:0] cidx_q;
   logic [7:0]       log_data_q;
   logic             log_valid_q;
   logic             last_char;

   function automatic logic [7:0] fmt_char(input logic [REC_W-1:0] rec, input int unsigned pos);
      logic [7:0]       cmd;
      logic [AW-1:0]    addr;
      logic [CNT_W-1:0] cnt;
      logic [7:0]       ch;
      {cmd, addr, cnt} = rec;
      if (pos < 2)             ch = hex_char(4'(cmd >> (4 * (1 - pos))));
      else if (pos < POS_ADDR) ch = 8'h20;
      else if (pos < POS_SP2)  ch = hex_char(4'(addr >> (4 * (POS_SP2 - 1 - pos))));
      else if (pos == POS_SP2) ch = 8'h20;
      else if (pos < POS_CR)   ch = hex_char(4'(cnt >> (4 * (POS_CR - 1 - pos))));
      else if (pos == POS_CR)  ch = 8'h0D;
      else                     ch = 8'h0A;
      return ch;
   endfunction

   // The head record stays in the queue until its last char is accepted, so it still counts as
   // occupancy while being printed.
   assign last_char = (cidx_q == IDX_W'(NCH - 1));
   assign fifo_pop  = (fmt_q == FmtEmit) && log_ready && last_char;

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         fmt_q       <= FmtIdle;
         cidx_q      <= '0;
         log_data_q  <= '0;
         log_valid_q <= 1'b0;
      end else begin
         unique case (fmt_q)
            FmtIdle: begin
               if (!fifo_empty) begin
                  fmt_q       <= FmtEmit;
                  cidx_q      <= '0;
                  log_data_q  <= fmt_char(fifo_rdata, 0);
                  log_valid_q <= 1'b1;
               end
            end
            FmtEmit: begin
               if (log_ready) begin
                  if (last_char) begin
                     fmt_q       <= FmtIdle;
                     log_valid_q <= 1'b0;
                  end else begin
                     cidx_q     <= cidx_q + IDX_W'(1);
                     log_data_q <= fmt_char(fifo_rdata, 32'(cidx_q) + 32'd1);
                  end
               end
            end
            default: fmt_q <= FmtIdle;
         endcase
      end
   end

   assign read_addr   = read_addr_q;
   assign read_active = read_active_q;
   assign log_data    = log_data_q;
   assign log_valid   = log_valid_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_spi_read_logger.sv
// Randomised scoreboard bench for spi_read_logger; expected text comes from a record-level model.
module tb_spi_read_logger;

   localparam int AB    = 3;
   localparam int DEPTH = 8;

   logic        mclk = 1'b0;
   logic        reset_n, spi_cs, rx_strobe, log_ready;
   logic [7:0]  rx_data;
   logic [23:0] read_addr;
   logic        read_active, log_valid, overflow;
   logic [7:0]  log_data;

   int n_tests = 0;
   int n_fail  = 0;
   byte unsigned exp_q[$];
   int    ready_mode;
   bit    stalled, exp_ovf;
   int    pend;
   string hx = "0123456789ABCDEF";

`ifdef SPI_LOG_FILTER_EN
   logic [23:0] filt_lo_v = 24'h000000;
   logic [23:0] filt_hi_v = 24'hFFFFFF;
`endif

   always #5 mclk = ~mclk;

   spi_read_logger dut (
      .mclk        (mclk),
      .reset_n     (reset_n),
      .spi_cs      (spi_cs),
      .rx_strobe   (rx_strobe),
      .rx_data     (rx_data),
`ifdef SPI_LOG_FILTER_EN
      .filt_lo     (filt_lo_v),
      .filt_hi     (filt_hi_v),
`endif
      .read_addr   (read_addr),
      .read_active (read_active),
      .log_data    (log_data),
      .log_valid   (log_valid),
      .log_ready   (log_ready),
      .overflow    (overflow)
   );

   function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic tick;
      @(posedge mclk);
      #1;
   endtask

   function void push_hex(input logic [31:0] v, input int nd);
      for (int i = nd - 1; i >= 0; i--) exp_q.push_back(hx[int'((v >> (4 * i)) & 32'hF)]);
   endfunction

   // One record's text; a stalled consumer means every unprinted record still occupies the queue.
   function void model_record(input byte unsigned cmd, input logic [23:0] addr, input int cnt);
      if (cnt > 65535) cnt = 65535;
`ifdef SPI_LOG_FILTER_EN
      if (addr < filt_lo_v || addr > filt_hi_v) return;
`endif
      if (stalled) begin
         if (pend >= DEPTH) begin
            exp_ovf = 1'b1;
            return;
         end
         pend++;
      end
      push_hex(32'(cmd), 2);
      exp_q.push_back(8'h20);
      push_hex(32'(addr), 6);
      exp_q.push_back(8'h20);
      push_hex(32'(cnt), 4);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   task automatic spi_read(input byte unsigned b[$], input int post);
      bit          valid;
      int          hdr;
      logic [23:0] a, e;
      valid = (b.size() > 0) && (b[0] == 8'h03 || b[0] == 8'h0B);
      hdr   = 1 + AB + ((b.size() > 0 && b[0] == 8'h0B) ? 1 : 0);
      a     = '0;
      if (b.size() > AB) a = {b[1], b[2], b[3]};
      spi_cs = 1'b0;
      repeat (6) tick;
      foreach (b[i]) begin
         rx_data   = b[i];
         rx_strobe = 1'b1;
         tick;
         rx_strobe = 1'b0;
         if (valid && i == AB) chk("addr_load", 32'(read_addr), 32'(a));
         if (valid && i >= hdr) begin
            e = a + 24'(i - hdr + 1);
            chk("addr_inc", 32'(read_addr), 32'(e));
            chk("active", 32'(read_active), 32'd1);
         end
         if ($urandom_range(0, 3) == 0) tick;
      end
      spi_cs = 1'b1;
      if (valid && b.size() >= hdr) model_record(b[0], a, b.size() - hdr);
      repeat (post) tick;
      if (post >= 4) chk("idle_after_rise", 32'(read_active), 32'd0);
   endtask

   task automatic drain;
      for (int k = 0; k < 5000; k++) begin
         if (exp_q.size() == 0 && !log_valid) break;
         tick;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (3) tick;
   endtask

   always @(posedge mclk) begin
      #1;
      case (ready_mode)
         0:       log_ready = 1'b0;
         1:       log_ready = 1'b1;
         default: log_ready = ($urandom_range(0, 7) != 0);
      endcase
   end

   // Monitor: every accepted char is checked against the scoreboard; stalled bytes must hold.
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data  = '0;
   always @(negedge mclk) begin
      if (!reset_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("stall_stable", {23'd0, log_valid, log_data}, {23'd0, 1'b1, prev_data});
         if (log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_char: got %02h, expected none (t=%0t)", log_data, $time);
            end else begin
               chk("char", 32'(log_data), 32'(exp_q.pop_front()));
            end
         end
         stall_prev = log_valid && !log_ready;
         prev_data  = log_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      byte unsigned q[$];
      byte unsigned op;
      int r, hdr, tot;
      reset_n    = 1'b0;
      spi_cs     = 1'b1;
      rx_strobe  = 1'b0;
      rx_data    = '0;
      log_ready  = 1'b0;
      ready_mode = 1;
      stalled    = 1'b0;
      exp_ovf    = 1'b0;
      pend       = 0;
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_read_addr", 32'(read_addr), 32'd0);
      chk("rst_active", 32'(read_active), 32'd0);
      chk("rst_log_valid", 32'(log_valid), 32'd0);
      chk("rst_log_data", 32'(log_data), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset_n = 1'b1;
      repeat (4) tick;

      // Plain READ, then FAST_READ with and without 24-bit wrap.
      q = {8'h03, 8'h12, 8'h34, 8'h56, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
      spi_read(q, 6);
      drain;
      ready_mode = 2;
      q = {8'h0B, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hD1, 8'hD2};
      spi_read(q, 6);
      q = {8'h0B, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hD1, 8'hD2};
      spi_read(q, 6);
      drain;

      // Unknown opcode and truncated commands log nothing.
      q = {8'h9F, 8'h01, 8'h02, 8'h03};
      spi_read(q, 6);
      q = {8'h03, 8'h12};
      spi_read(q, 6);
      q = {8'h0B, 8'h01, 8'h02, 8'h03};
      spi_read(q, 6);
      repeat (30) tick;
      chk("no_output_valid", 32'(log_valid), 32'd0);
      chk("no_output_ovf", 32'(overflow), 32'd0);
      drain;

      // Back-to-back reads while the formatter is busy.
      for (int t = 0; t < 3; t++) begin
         q = {8'h03, 8'($urandom), 8'($urandom), 8'($urandom), 8'h11, 8'h22};
         spi_read(q, 2);
      end
      drain;

      // Random mix of commands, lengths and truncations.
      for (int t = 0; t < 25; t++) begin
         r   = $urandom_range(0, 7);
         op  = (r < 4) ? 8'h03 : (r < 6) ? 8'h0B : (r == 6) ? 8'h9F : 8'($urandom);
         hdr = 1 + AB + ((op == 8'h0B) ? 1 : 0);
         if (op != 8'h03 && op != 8'h0B)   tot = $urandom_range(1, 5);
         else if ($urandom_range(0, 5) == 0) tot = $urandom_range(1, hdr - 1);
         else                                tot = hdr + $urandom_range(0, 6);
         q = {};
         q.push_back(op);
         for (int i = 1; i < tot; i++) q.push_back(8'($urandom));
         spi_read(q, $urandom_range(2, 6));
         if (t % 8 == 7) drain;
      end
      drain;
      chk("random_ovf", 32'(overflow), 32'd0);

      // Consumer stalled: one more complete read than the queue can hold.
      ready_mode = 0;
      stalled    = 1'b1;
      pend       = 0;
      exp_ovf    = 1'b0;
      repeat (2) tick;
      for (int t = 0; t < DEPTH + 1; t++) begin
         q = {8'h03, 8'($urandom), 8'($urandom), 8'($urandom)};
         tot = $urandom_range(1, 3);
         for (int i = 0; i < tot; i++) q.push_back(8'($urandom));
         spi_read(q, 5);
      end
      repeat (20) tick;
      chk("stall_ovf", 32'(overflow), 32'(exp_ovf));
      ready_mode = 2;
      stalled    = 1'b0;
      drain;
      chk("ovf_sticky", 32'(overflow), 32'(exp_ovf));

      // Reset asserted in the middle of a DATA phase.
      spi_cs = 1'b0;
      repeat (6) tick;
      q = {8'h03, 8'h00, 8'h01, 8'h02, 8'h55, 8'h66};
      foreach (q[i]) begin
         rx_data   = q[i];
         rx_strobe = 1'b1;
         tick;
         rx_strobe = 1'b0;
      end
      chk("pre_rst_active", 32'(read_active), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_read_addr", 32'(read_addr), 32'd0);
      chk("mid_rst_active", 32'(read_active), 32'd0);
      chk("mid_rst_log_valid", 32'(log_valid), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      spi_cs = 1'b1;
      repeat (4) tick;
      reset_n = 1'b1;
      repeat (4) tick;
      q = {8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h02, 8'h03};
      spi_read(q, 6);
      drain;
      chk("post_rst_ovf", 32'(overflow), 32'd0);

`ifdef SPI_LOG_FILTER_EN
      filt_lo_v = 24'h001000;
      filt_hi_v = 24'h001FFF;
      q = {8'h03, 8'h00, 8'h0F, 8'hFF, 8'h01, 8'h02};
      spi_read(q, 6);
      q = {8'h03, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02};
      spi_read(q, 6);
      q = {8'h03, 8'h00, 8'h20, 8'h00, 8'h01, 8'h02};
      spi_read(q, 6);
      drain;
      chk("filter_ovf", 32'(overflow), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
